itlb_maint_ctrl: RTL and testbench
==================================

Name: itlb_maint_ctrl

Overview:
- TLB-maintenance engine that owns the instruction-TLB entry array and executes tlbwe, tlbre, tlbivax and tlbia requests issued through a MAS-style register interface.
- Acts as writer/maintainer for the array; the IMMU hit-judge reads the same array through the flattened entry bus.
- Multi-cycle invalidation scan, round-robin victim selection, valid/ready request handshake with done pulse.

Parameters:
- ESEL_W, 4, entry-index width; ENTRIES = 2**ESEL_W (16).
- ENTRY_W, 57, fixed per-entry width: V, TS, TID[7:0], EPN[19:0], RPN[19:0], PERMIS[5:0], IPROT. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- op_valid  in  1  request valid.
- op_code  in  3  001 tlbwe, 010 tlbre, 011 tlbivax, 100 tlbia; others illegal.
- op_ready  out  1  engine idle, request accepted when op_valid & op_ready.
- op_done  out  1  one-cycle completion pulse.
- op_err  out  1  valid only with op_done; 1 = illegal opcode.
- mas_esel  in  ESEL_W  target entry for tlbwe/tlbre.
- mas_hes  in  1  tlbwe uses victim_ptr instead of mas_esel.
- mas_v, mas_ts, mas_iprot  in  1 each  entry fields to write.
- mas_tid  in  8; mas_epn  in  20; mas_rpn  in  20; mas_permis  in  6  entry fields to write.
- ivax_ea  in  32  tlbivax effective address.
- rd_v, rd_ts, rd_iprot  out  1 each  tlbre result.
- rd_tid  out  8; rd_epn  out  20; rd_rpn  out  20; rd_permis  out  6  tlbre result.
- victim_ptr  out  ESEL_W  round-robin replacement index.
- tlb_busy  out  1  high in any non-IDLE state; IMMU forces Miss while high.
- tlb_flat  out  ENTRIES*ENTRY_W  all entries, entry i at bits [i*57 +: 57], registered.

Behaviour:
- Reset (rst=0, async): state IDLE, all entry bits 0, victim_ptr=0, rd_* =0, op_done=0, op_err=0, tlb_busy=0. op_ready=1 from the first clock after deassert. Reset mid-operation aborts it; no partial-completion guarantee.
- States: IDLE, WRITE, READ, SCAN, DONE.
- IDLE: op_ready=1. On accept at cycle T, latch op_code, index (victim_ptr if mas_hes, else mas_esel), all mas_* and ivax_ea[31:12]. Next state: WRITE (001), READ (010), SCAN (011/100), DONE with err flag (others).
- Inputs are not sampled while op_ready=0. Requester holds op_valid.
- WRITE (T+1): entry[index] written at end of cycle. If mas_hes=1, victim_ptr increments modulo ENTRIES at the same edge (wraps 15->0). Next state DONE.
- READ (T+1): rd_* loaded from entry[index] at end of cycle and held until the next tlbre. Next state DONE.
- SCAN: scan index starts at 0 and increments each cycle for ENTRIES cycles (T+1 .. T+ENTRIES).
  - tlbia: clears V of entry[idx].
  - tlbivax: clears V only if EPN==latched ivax_ea[31:12]; TID and TS are ignored.
  - Non-matching entries are untouched.
  - After idx=ENTRIES-1, next state DONE.
- DONE: op_done=1 for exactly one cycle. op_err=1 only for an illegal opcode. Next state IDLE; op_ready=1 the following cycle.
- Latencies (accept at T):
  - Legal tlbwe/tlbre: op_done at T+2, next accept possible at T+3.
  - Scan: op_done at T+ENTRIES+1.
  - Illegal opcode: op_done at T+1.
- tlb_flat reflects array state registered; an updated entry is visible the cycle after its write edge.
- Back-to-back tlbwe to the same index: last write wins. tlbre after tlbwe returns the new data.

Optional Feature:
- Macro ITLB_IPROT_EN.
- Defined: IPROT bit stored from mas_iprot and returned on rd_iprot. tlbivax and tlbia skip entries with IPROT=1 (V unchanged). tlbwe overwrites regardless of IPROT.
- Undefined: mas_iprot ignored, stored IPROT and rd_iprot tied 0, all matching entries invalidated. Port list unchanged.

Test Plan:
- Reset, then tlbwe esel=3, V=1, TS=0, TID=0x12, EPN=0x40000, RPN=0x00123, PERMIS=0x2A -> op_done at T+2, op_err=0, tlb_flat entry 3 holds values, then tlbre esel=3 -> rd_* equal written values.
- 17 consecutive tlbwe with mas_hes=1 -> entries 0..15 written in order, victim_ptr wraps to 1 after 17th write; 17th data lands in entry 0.
- Fill entries 0,5,9 with EPN=0x40000 (entry 9 TID differs), entry 2 with EPN=0x40001; tlbivax ea=0x40000ABC -> V cleared in 0,5,9, entry 2 V=1, op_done at T+17, tlb_busy high T+1..T+17.
- op_code=3'b111 -> op_done and op_err at T+1, array unchanged; op_valid held while busy during tlbia -> not accepted until op_ready=1.
- With ITLB_IPROT_EN, entry 4 IPROT=1, tlbia -> only entry 4 stays V=1. Without the macro -> all V=0, rd_iprot=0.
- Assert rst low mid-scan at idx=7 -> all entries V=0 immediately, state IDLE, op_done never pulses, victim_ptr=0.

Source files
------------

// File: rtl/itlb_maint_ctrl.sv
// rtl/itlb_maint_ctrl.sv - instruction-TLB maintenance engine (tlbwe/tlbre/tlbivax/tlbia)
// Optional macro ITLB_IPROT_EN: IPROT is stored and protected entries survive tlbivax/tlbia.
module itlb_maint_ctrl #(
  parameter  int ESEL_W  = 4,
  localparam int ENTRIES = 2**ESEL_W,
  localparam int ENTRY_W = 57
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid,
  input  logic [2:0]                  op_code,
  output logic                        op_ready,
  output logic                        op_done,
  output logic                        op_err,
  input  logic [ESEL_W-1:0]           mas_esel,
  input  logic                        mas_hes,
  input  logic                        mas_v,
  input  logic                        mas_ts,
  input  logic                        mas_iprot,
  input  logic [7:0]                  mas_tid,
  input  logic [19:0]                 mas_epn,
  input  logic [19:0]                 mas_rpn,
  input  logic [5:0]                  mas_permis,
  input  logic [31:0]                 ivax_ea,
  output logic                        rd_v,
  output logic                        rd_ts,
  output logic                        rd_iprot,
  output logic [7:0]                  rd_tid,
  output logic [19:0]                 rd_epn,
  output logic [19:0]                 rd_rpn,
  output logic [5:0]                  rd_permis,
  output logic [ESEL_W-1:0]           victim_ptr,
  output logic                        tlb_busy,
  output logic [ENTRIES*ENTRY_W-1:0]  tlb_flat
);

  // Entry layout, MSB first: V, TS, TID[7:0], EPN[19:0], RPN[19:0], PERMIS[5:0], IPROT
  localparam int V_POS     = 56;
  localparam int EPN_LSB   = 27;
  localparam int IPROT_POS = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state;
  logic [ENTRY_W-1:0]  ent [ENTRIES];
  logic [ESEL_W-1:0]   lat_idx;
  logic [ESEL_W-1:0]   scan_idx;
  logic                lat_hes;
  logic                lat_ia;
  logic                lat_err;
  logic [ENTRY_W-1:0]  lat_entry;
  logic [19:0]         lat_epn;
  logic                iprot_in;
  logic                scan_protect;
  logic                scan_match;
  logic [11:0]         unused_ea_lo;

  assign unused_ea_lo = ivax_ea[11:0];

`ifdef ITLB_IPROT_EN
  assign iprot_in     = mas_iprot;
  assign scan_protect = ent[scan_idx][IPROT_POS];
`else
  logic unused_iprot;
  assign unused_iprot = mas_iprot;
  assign iprot_in     = 1'b0;
  assign scan_protect = 1'b0;
`endif

  // tlbia matches every entry; tlbivax compares EPN only (TID/TS deliberately ignored)
  assign scan_match = (lat_ia || (ent[scan_idx][EPN_LSB +: 20] == lat_epn)) && !scan_protect;

  assign op_ready = (state == S_IDLE);
  assign op_done  = (state == S_DONE);
  assign op_err   = op_done & lat_err;
  assign tlb_busy = (state != S_IDLE);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_flat
    assign tlb_flat[g*ENTRY_W +: ENTRY_W] = ent[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      victim_ptr <= '0;
      lat_idx    <= '0;
      scan_idx   <= '0;
      lat_hes    <= 1'b0;
      lat_ia     <= 1'b0;
      lat_err    <= 1'b0;
      lat_entry  <= '0;
      lat_epn    <= '0;
      {rd_v, rd_ts, rd_tid, rd_epn, rd_rpn, rd_permis, rd_iprot} <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            lat_idx   <= mas_hes ? victim_ptr : mas_esel;
            lat_hes   <= mas_hes;
            lat_entry <= {mas_v, mas_ts, mas_tid, mas_epn, mas_rpn, mas_permis, iprot_in};
            lat_epn   <= ivax_ea[31:12];
            lat_ia    <= (op_code == 3'b100);
            lat_err   <= 1'b0;
            scan_idx  <= '0;
            case (op_code)
              3'b001:         state <= S_WRITE;
              3'b010:         state <= S_READ;
              3'b011, 3'b100: state <= S_SCAN;
              default: begin
                lat_err <= 1'b1;
                state   <= S_DONE;
              end
            endcase
          end
        end
        S_WRITE: begin
          ent[lat_idx] <= lat_entry;
          if (lat_hes) victim_ptr <= victim_ptr + 1'b1;
          state <= S_DONE;
        end
        S_READ: begin
          {rd_v, rd_ts, rd_tid, rd_epn, rd_rpn, rd_permis, rd_iprot} <= ent[lat_idx];
          state <= S_DONE;
        end
        S_SCAN: begin
          if (scan_match) ent[scan_idx][V_POS] <= 1'b0;
          scan_idx <= scan_idx + 1'b1;
          if (&scan_idx) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_itlb_maint_ctrl.sv
// tb/tb_itlb_maint_ctrl.sv - randomized self-checking bench for itlb_maint_ctrl
// Reference model keeps the TLB as per-field arrays and applies each operation's rule directly.
module tb_itlb_maint_ctrl;
  localparam int N  = 16;
  localparam int EW = 57;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic op_valid = 1'b0;
  logic [2:0] op_code = '0;
  logic op_ready, op_done, op_err;
  logic [3:0] mas_esel = '0;
  logic mas_hes = 1'b0, mas_v = 1'b0, mas_ts = 1'b0, mas_iprot = 1'b0;
  logic [7:0] mas_tid = '0;
  logic [19:0] mas_epn = '0, mas_rpn = '0;
  logic [5:0] mas_permis = '0;
  logic [31:0] ivax_ea = '0;
  logic rd_v, rd_ts, rd_iprot;
  logic [7:0] rd_tid;
  logic [19:0] rd_epn, rd_rpn;
  logic [5:0] rd_permis;
  logic [3:0] victim_ptr;
  logic tlb_busy;
  logic [N*EW-1:0] tlb_flat;

  itlb_maint_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .op_done(op_done), .op_err(op_err), .mas_esel(mas_esel), .mas_hes(mas_hes),
    .mas_v(mas_v), .mas_ts(mas_ts), .mas_iprot(mas_iprot), .mas_tid(mas_tid),
    .mas_epn(mas_epn), .mas_rpn(mas_rpn), .mas_permis(mas_permis), .ivax_ea(ivax_ea),
    .rd_v(rd_v), .rd_ts(rd_ts), .rd_iprot(rd_iprot), .rd_tid(rd_tid), .rd_epn(rd_epn),
    .rd_rpn(rd_rpn), .rd_permis(rd_permis), .victim_ptr(victim_ptr), .tlb_busy(tlb_busy),
    .tlb_flat(tlb_flat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_v [N];
  logic        m_ts [N];
  logic        m_ip [N];
  logic [7:0]  m_tid [N];
  logic [19:0] m_epn [N];
  logic [19:0] m_rpn [N];
  logic [5:0]  m_perm [N];
  int          m_victim;
  logic [EW-1:0] e_rd;

  function automatic logic prot_en();
`ifdef ITLB_IPROT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [EW-1:0] m_entry(input int i);
    return {m_v[i], m_ts[i], m_tid[i], m_epn[i], m_rpn[i], m_perm[i], m_ip[i]};
  endfunction

  function automatic logic [N*EW-1:0] exp_flat();
    logic [N*EW-1:0] f;
    for (int i = 0; i < N; i++) f[i*EW +: EW] = m_entry(i);
    return f;
  endfunction

  function automatic logic [EW-1:0] dut_entry(input int i);
    return tlb_flat[i*EW +: EW];
  endfunction

  function automatic int exp_lat(input logic [2:0] code);
    if (code == 3'd1 || code == 3'd2) return 2;
    if (code == 3'd3 || code == 3'd4) return N + 1;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_ts[i] = 0; m_ip[i] = 0; m_tid[i] = 0;
      m_epn[i] = 0; m_rpn[i] = 0; m_perm[i] = 0;
    end
    m_victim = 0;
    e_rd = '0;
  endtask

  task automatic model_apply(input logic [2:0] code);
    int idx;
    idx = mas_hes ? m_victim : int'(mas_esel);
    case (code)
      3'd1: begin
        m_v[idx] = mas_v; m_ts[idx] = mas_ts; m_tid[idx] = mas_tid; m_epn[idx] = mas_epn;
        m_rpn[idx] = mas_rpn; m_perm[idx] = mas_permis; m_ip[idx] = prot_en() & mas_iprot;
        if (mas_hes) m_victim = (m_victim + 1) % N;
      end
      3'd2: e_rd = m_entry(idx);
      3'd3, 3'd4: begin
        for (int i = 0; i < N; i++)
          if ((code == 3'd4 || m_epn[i] == ivax_ea[31:12]) && !(prot_en() && m_ip[i])) m_v[i] = 0;
      end
      default: ;
    endcase
  endtask

  task automatic set_random_fields();
    mas_esel = 4'($urandom); mas_hes = 1'b0; mas_v = 1'($urandom); mas_ts = 1'($urandom);
    mas_iprot = ($urandom_range(0, 3) == 0); mas_tid = 8'($urandom);
    mas_epn = 20'($urandom); mas_rpn = 20'($urandom); mas_permis = 6'($urandom);
  endtask

  // Returns cycles from the accepting cycle to op_done, and how many of those cycles had tlb_busy high.
  task automatic issue(input logic [2:0] code, output int lat, output int busy_n, output logic err);
    int w, t0;
    lat = -1; busy_n = 0; err = 1'b0;
    @(negedge clk);
    op_code = code; op_valid = 1'b1; w = 0;
    while (!op_ready && w < 100) begin @(negedge clk); w++; end
    if (!op_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_ready_timeout op_ready=%0b required 1", op_ready);
      op_valid = 1'b0;
      return;
    end
    t0 = cyc;
    @(negedge clk);
    op_valid = 1'b0; w = 0;
    forever begin
      if (tlb_busy) busy_n++;
      if (op_done) begin lat = cyc - t0; err = op_err; break; end
      if (w >= 50) begin
        n_tests++; n_fail++;
        $display("FAIL issue_done_timeout op_done=%0b required 1", op_done);
        break;
      end
      @(negedge clk); w++;
    end
  endtask

  task automatic wr_entry(input int idx, input logic v, input logic [7:0] tid,
                          input logic [19:0] epn, input logic ip);
    int lat, bn; logic err;
    set_random_fields();
    mas_esel = 4'(idx); mas_v = v; mas_tid = tid; mas_epn = epn; mas_iprot = ip;
    issue(3'd1, lat, bn, err);
    model_apply(3'd1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (tlb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", tlb_busy); end
    n_tests++; if (op_done !== 1'b0 || op_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got=%0b%0b exp=00", op_done, op_err); end
    n_tests++; if (victim_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_victim got=%0d exp=0", victim_ptr); end
    n_tests++; if (tlb_flat !== '0) begin n_fail++; $display("FAIL reset_flat got=%h exp=0", tlb_flat); end
    n_tests++; if ({rd_v, rd_ts, rd_tid, rd_epn, rd_rpn, rd_permis, rd_iprot} !== '0) begin n_fail++; $display("FAIL reset_rd got=%h exp=0", {rd_v, rd_ts, rd_tid, rd_epn, rd_rpn, rd_permis, rd_iprot}); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", op_ready); end
  endtask

  task automatic test_write_read();
    int lat, bn; logic err;
    mas_esel = 4'd3; mas_hes = 0; mas_v = 1; mas_ts = 0; mas_iprot = 0;
    mas_tid = 8'h12; mas_epn = 20'h40000; mas_rpn = 20'h00123; mas_permis = 6'h2A;
    issue(3'd1, lat, bn, err);
    model_apply(3'd1);
    n_tests++; if (lat !== 2 || err !== 1'b0) begin n_fail++; $display("FAIL wr_latency got=%0d/%0b exp=2/0", lat, err); end
    n_tests++; if (dut_entry(3) !== {1'b1, 1'b0, 8'h12, 20'h40000, 20'h00123, 6'h2A, 1'b0}) begin n_fail++; $display("FAIL wr_entry3 got=%h", dut_entry(3)); end
    @(negedge clk);
    n_tests++; if (op_ready !== 1'b1 || tlb_busy !== 1'b0) begin n_fail++; $display("FAIL wr_ready_t3 got=%0b/%0b exp=1/0", op_ready, tlb_busy); end
    mas_tid = 8'h00; mas_epn = 20'h0;
    issue(3'd2, lat, bn, err);
    model_apply(3'd2);
    n_tests++; if (lat !== 2 || err !== 1'b0) begin n_fail++; $display("FAIL rd_latency got=%0d/%0b exp=2/0", lat, err); end
    n_tests++; if ({rd_v, rd_ts, rd_tid, rd_epn, rd_rpn, rd_permis, rd_iprot} !== e_rd || rd_epn !== 20'h40000 || rd_tid !== 8'h12) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", {rd_v, rd_ts, rd_tid, rd_epn, rd_rpn, rd_permis, rd_iprot}, e_rd); end
  endtask

  task automatic test_victim_wrap();
    int lat, bn, bad; logic err; logic [EW-1:0] last;
    bad = 0;
    for (int k = 0; k < 17; k++) begin
      set_random_fields();
      mas_hes = 1'b1;
      issue(3'd1, lat, bn, err);
      if (lat != 2) bad++;
      model_apply(3'd1);
    end
    last = m_entry(0);
    mas_hes = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hes_latency bad_count=%0d exp=0", bad); end
    n_tests++; if (victim_ptr !== 4'd1) begin n_fail++; $display("FAIL hes_victim_wrap got=%0d exp=1", victim_ptr); end
    n_tests++; if (dut_entry(0) !== last) begin n_fail++; $display("FAIL hes_entry0 got=%h exp=%h", dut_entry(0), last); end
    n_tests++; if (tlb_flat !== exp_flat()) begin n_fail++; $display("FAIL hes_flat got=%h exp=%h", tlb_flat, exp_flat()); end
  endtask

  task automatic test_ivax();
    int lat, bn; logic err;
    wr_entry(0, 1, 8'h11, 20'h40000, 0);
    wr_entry(5, 1, 8'h11, 20'h40000, 0);
    wr_entry(9, 1, 8'h77, 20'h40000, 0);
    wr_entry(2, 1, 8'h11, 20'h40001, 0);
    ivax_ea = 32'h40000ABC;
    issue(3'd3, lat, bn, err);
    model_apply(3'd3);
    n_tests++; if (lat !== 17 || err !== 1'b0) begin n_fail++; $display("FAIL ivax_latency got=%0d/%0b exp=17/0", lat, err); end
    n_tests++; if (bn !== 17) begin n_fail++; $display("FAIL ivax_busy_cycles got=%0d exp=17", bn); end
    n_tests++; if (tlb_flat[0*EW+56] !== 1'b0 || tlb_flat[5*EW+56] !== 1'b0 || tlb_flat[9*EW+56] !== 1'b0 || tlb_flat[2*EW+56] !== 1'b1) begin n_fail++; $display("FAIL ivax_vbits got=%0b%0b%0b%0b exp=0001", tlb_flat[0*EW+56], tlb_flat[5*EW+56], tlb_flat[9*EW+56], tlb_flat[2*EW+56]); end
    n_tests++; if (tlb_flat !== exp_flat()) begin n_fail++; $display("FAIL ivax_flat got=%h exp=%h", tlb_flat, exp_flat()); end
  endtask

  task automatic test_illegal();
    logic [2:0] codes [4];
    int lat, bn; logic err;
    codes[0] = 3'b000; codes[1] = 3'b101; codes[2] = 3'b110; codes[3] = 3'b111;
    for (int k = 0; k < 4; k++) begin
      set_random_fields();
      issue(codes[k], lat, bn, err);
      n_tests++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL illegal_%0d got=%0d/%0b exp=1/1", codes[k], lat, err); end
    end
    n_tests++; if (tlb_flat !== exp_flat()) begin n_fail++; $display("FAIL illegal_flat got=%h exp=%h", tlb_flat, exp_flat()); end
  endtask

  task automatic test_busy_hold();
    int bad, done_at, w;
    @(negedge clk);
    op_code = 3'd4; op_valid = 1'b1; w = 0;
    while (!op_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    op_code = 3'b111;
    bad = 0; done_at = -1;
    for (int k = 1; k <= 17; k++) begin
      if (op_ready) bad++;
      if (op_done && done_at < 0) done_at = k;
      if (k < 17) @(negedge clk);
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_ready_while_busy cycles_ready=%0d exp=0", bad); end
    n_tests++; if (done_at !== 17 || op_err !== 1'b0) begin n_fail++; $display("FAIL hold_tlbia_done got=%0d/%0b exp=17/0", done_at, op_err); end
    model_apply(3'd4);
    @(negedge clk);
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_after got=%0b exp=1", op_ready); end
    @(negedge clk);
    op_valid = 1'b0;
    n_tests++; if (op_done !== 1'b1 || op_err !== 1'b1) begin n_fail++; $display("FAIL hold_illegal_done got=%0b/%0b exp=1/1", op_done, op_err); end
    n_tests++; if (tlb_flat !== exp_flat()) begin n_fail++; $display("FAIL hold_flat got=%h exp=%h", tlb_flat, exp_flat()); end
  endtask

  task automatic test_iprot();
    int lat, bn, nv; logic err;
    for (int i = 0; i < N; i++) wr_entry(i, 1, 8'($urandom), 20'($urandom), (i == 4));
    issue(3'd4, lat, bn, err);
    model_apply(3'd4);
    nv = 0;
    for (int i = 0; i < N; i++) nv += int'(tlb_flat[i*EW+56]);
    n_tests++; if (nv !== (prot_en() ? 1 : 0) || tlb_flat[4*EW+56] !== prot_en()) begin n_fail++; $display("FAIL iprot_tlbia valid_count=%0d e4v=%0b exp=%0d/%0b", nv, tlb_flat[4*EW+56], prot_en() ? 1 : 0, prot_en()); end
    n_tests++; if (tlb_flat !== exp_flat()) begin n_fail++; $display("FAIL iprot_flat got=%h exp=%h", tlb_flat, exp_flat()); end
    mas_esel = 4'd4; mas_hes = 1'b0;
    issue(3'd2, lat, bn, err);
    model_apply(3'd2);
    n_tests++; if (rd_iprot !== prot_en() || rd_v !== prot_en()) begin n_fail++; $display("FAIL iprot_read got=%0b/%0b exp=%0b/%0b", rd_iprot, rd_v, prot_en(), prot_en()); end
  endtask

  task automatic test_random();
    int lat, bn, r, bad_lat, bad_rd, bad_flat; logic err; logic [2:0] code;
    bad_lat = 0; bad_rd = 0; bad_flat = 0;
    for (int k = 0; k < 40; k++) begin
      set_random_fields();
      mas_hes = 1'($urandom);
      r = $urandom_range(0, 19);
      if (r < 8) code = 3'd1;
      else if (r < 13) code = 3'd2;
      else if (r < 17) code = 3'd3;
      else if (r < 18) code = 3'd4;
      else code = 3'd6;
      ivax_ea = ($urandom_range(0, 3) != 0) ? {m_epn[$urandom_range(0, N-1)], 12'($urandom)} : $urandom;
      issue(code, lat, bn, err);
      model_apply(code);
      if (lat != exp_lat(code) || err !== (code == 3'd6) || bn != lat) bad_lat++;
      if ({rd_v, rd_ts, rd_tid, rd_epn, rd_rpn, rd_permis, rd_iprot} !== e_rd) bad_rd++;
      if (tlb_flat !== exp_flat() || victim_ptr !== 4'(m_victim)) bad_flat++;
    end
    n_tests++; if (bad_lat != 0) begin n_fail++; $display("FAIL rand_latency_err bad_ops=%0d exp=0", bad_lat); end
    n_tests++; if (bad_rd != 0) begin n_fail++; $display("FAIL rand_read bad_ops=%0d exp=0", bad_rd); end
    n_tests++; if (bad_flat != 0) begin n_fail++; $display("FAIL rand_array bad_ops=%0d exp=0", bad_flat); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, bn, w, pulses; logic err;
    for (int i = 0; i < 4; i++) wr_entry(i, 1, 8'h5A, 20'h12345 + 20'(i), 0);
    mas_hes = 1'b1;
    issue(3'd1, lat, bn, err);
    model_apply(3'd1);
    mas_hes = 1'b0; mas_esel = 4'd1;
    issue(3'd2, lat, bn, err);
    @(negedge clk);
    op_code = 3'd4; op_valid = 1'b1; w = 0;
    while (!op_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    op_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    model_reset();
    n_tests++; if (tlb_flat !== '0 || victim_ptr !== 4'd0) begin n_fail++; $display("FAIL midscan_clear flat_nonzero=%0b victim=%0d exp=0/0", |tlb_flat, victim_ptr); end
    n_tests++; if (tlb_busy !== 1'b0 || op_done !== 1'b0 || rd_epn !== 20'd0) begin n_fail++; $display("FAIL midscan_state busy=%0b done=%0b rd_epn=%h exp=0/0/0", tlb_busy, op_done, rd_epn); end
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (25) begin @(negedge clk); if (op_done) pulses++; end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL midscan_no_done pulses=%0d exp=0", pulses); end
    set_random_fields();
    issue(3'd1, lat, bn, err);
    model_apply(3'd1);
    n_tests++; if (lat !== 2 || tlb_flat !== exp_flat()) begin n_fail++; $display("FAIL midscan_recover lat=%0d exp=2", lat); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_victim_wrap();
    test_ivax();
    test_illegal();
    test_busy_hold();
    test_iprot();
    test_random();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
